score_render: RTL and testbench
===============================

# score_render

Renders the 4-digit BCD game score into the VGA pixel stream. Sits directly downstream of the score counter and alongside the sprite renderers. It snapshots the score once per frame so digits never tear mid-frame, and maps the current beam position to a glyph pixel through a 2-stage pipeline. It produces a single `pixel_on` bit that the colour mixer ORs with the other layers.

## Interface
Parameters:
- `ORIGIN_X`, default 560: screen x of the score's top-left pixel.
- `ORIGIN_Y`, default 16: screen y of the score's top-left pixel.
- `SCALE_LOG2`, default 1: each glyph pixel is drawn as a 2^SCALE_LOG2 square.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `score` in 16: live BCD score, `[15:12]` = thousands … `[3:0]` = ones.
- `game_tick` in 1: 1-cycle end-of-frame pulse.
- `game_over` in 1: 1-cycle pulse at end of game. Used only with `SCORE_HISCORE_EN`.
- `hpos` in 10: current beam x.
- `vpos` in 10: current beam y.
- `pixel_on` out 1: score pixel lit, registered.
- `hiscore` out 16: BCD high score. Present only with `SCORE_HISCORE_EN`.

## Operation
- Snapshot: `shown` (16-bit) loads `score` on any cycle with `game_tick`=1, otherwise holds. Reset value 0x0000.
- Region test, unsigned 10-bit:
  - `dx = hpos - ORIGIN_X`, `dy = vpos - ORIGIN_Y`.
  - In-region iff `hpos >= ORIGIN_X`, `hpos < ORIGIN_X + (16<<SCALE_LOG2)`, `vpos >= ORIGIN_Y` and `vpos < ORIGIN_Y + (5<<SCALE_LOG2)`.
  - Out-of-region gives 0. Any region extending past 1023 is clipped; there is no wrap.
- Glyph coordinates:
  - `ux = dx >> SCALE_LOG2` (0..15) and `uy = dy >> SCALE_LOG2` (0..4).
  - Digit index `ux[3:2]`: 0 = thousands, leftmost.
  - Column `ux[1:0]`. Column 3 is the inter-digit gap and is always 0.
- Font: 3×5 glyphs. Row bit 2 is the leftmost column.
  - '1' = 010,110,010,010,111.
  - '8' = 111,101,111,101,111.
  - '0' = 111,101,101,101,111.
- Leading-zero blanking: a digit is blank if it and every digit to its left are 0. The ones digit is never blanked, so 0x0000 shows "0".
- Invalid nibble (>9): the whole 3×5 area of that digit is lit. An invalid nibble counts as nonzero for blanking.

## Timing
- Stage 1 registers: in-region flag, digit value (selected from `shown`), blank flag, column, row.
- Stage 2 registers: `pixel_on` = font lookup & column≠3 & in-region & !blank.
- Latency is exactly 2 cycles from `hpos`/`vpos` to `pixel_on`. Throughput is 1 pixel per cycle.
- Reset values:
  - All pipeline registers 0.
  - `pixel_on` 0.
  - `hiscore` 0x0000.
- `game_tick` mid-scan: the new `shown` affects pixels whose stage 1 occurs the cycle after the tick. Upstream guarantees the tick falls in blanking.
- Reset mid-frame: `pixel_on` goes 0 immediately and stays 0 for 2 cycles after release.

## Configuration
- `SCORE_HISCORE_EN` defined:
  - `hiscore` register and port exist.
  - On a `game_over` pulse with `score > hiscore` (binary compare, valid for BCD), `hiscore <= score`. Equal or lower leaves it unchanged.
  - `game_over` and `game_tick` in the same cycle both take effect independently.
  - A second row renders `hiscore` at y = `ORIGIN_Y + (7<<SCALE_LOG2)`, with the same x origin, height, blanking and invalid-nibble rules. `pixel_on` is the OR of both rows, with the same 2-cycle latency.
  - `hiscore` is not snapshotted. It changes only on `game_over`.
- `SCORE_HISCORE_EN` undefined:
  - Single row only. No `hiscore` register or port; `game_over` is ignored.

## Structure
- `score_render_pkg` holds:
  - `GLYPH_W`=3, `GLYPH_H`=5, `CELL_W`=4, `NUM_DIGITS`=4, `HI_ROW_GAP`=7.
  - Font constant: 10 digits × 5 rows × 3 bits.
- Sub-module `score_glyph_rom`: combinational, 4-bit digit + 3-bit row → 3-bit row pattern, with the invalid-digit → 111 rule. Instantiated once per rendered row.

## Test plan
Defaults: `ORIGIN_X`=560, `ORIGIN_Y`=16, `SCALE_LOG2`=1.
- Reset: `pixel_on`=0 for any beam position; `hiscore`=0x0000.
- Blanking: `score`=0x0042, pulse `game_tick`, scan the region.
  - x 560–575 (thousands/hundreds) all 0.
  - Tens cell shows '4'; ones cell shows '2'.
- Snapshot: after showing 0x0042, set `score`=0x0999 with no tick → image unchanged. Pulse `game_tick` → "999" shown, thousands blank.
- Latency and scale with `score`=0x8000 shown:
  - hpos=560, vpos=16 → `pixel_on`=1 exactly 2 cycles later.
  - hpos=559 → 0.
  - hpos=562–563, vpos=18 (glyph col 1, row 1) → 0.
  - hpos=566, vpos=16 (gap column) → 0.
- Invalid nibble: `score`=0x00A0 → tens cell lit over hpos 576–581, vpos 16–25; ones shows '0'.
- `SCORE_HISCORE_EN`:
  - `score`=0x0123 + `game_over` → `hiscore`=0x0123 and row 2 shows "123" at vpos 30–39.
  - Then `score`=0x0099 + `game_over` → `hiscore` stays 0x0123.

Source files
------------

// File: rtl/score_render_pkg.sv
// rtl/score_render_pkg.sv - shared glyph geometry and 3x5 digit font for the score renderer
package score_render_pkg;

  localparam int GLYPH_W    = 3;
  localparam int GLYPH_H    = 5;
  localparam int CELL_W     = 4;
  localparam int NUM_DIGITS = 4;
  localparam int HI_ROW_GAP = 7;

  // One entry per digit, row 0 in bits [14:12]; bit 2 of each row is the leftmost column.
  localparam logic [9:0][14:0] FONT = {
    15'b111_101_111_001_111,  // 9
    15'b111_101_111_101_111,  // 8
    15'b111_001_001_001_001,  // 7
    15'b111_100_111_101_111,  // 6
    15'b111_100_111_001_111,  // 5
    15'b101_101_111_001_001,  // 4
    15'b111_001_111_001_111,  // 3
    15'b111_001_111_100_111,  // 2
    15'b010_110_010_010_111,  // 1
    15'b111_101_101_101_111   // 0
  };

endpackage

// File: rtl/score_glyph_rom.sv
// rtl/score_glyph_rom.sv - combinational font lookup: digit + row -> 3-bit row pattern
module score_glyph_rom
  import score_render_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] row,
  output logic [2:0] pattern
);

  always_comb begin
    pattern = '0;
    if (row < 3'(GLYPH_H)) begin
      // Non-BCD nibbles render as a solid block so corruption is visible on screen.
      if (digit > 4'd9) pattern = 3'b111;
      else              pattern = FONT[digit][3 * (GLYPH_H - 1 - int'(row)) +: 3];
    end
  end

endmodule

// File: rtl/score_render.sv
// rtl/score_render.sv - renders the frame-snapshotted BCD score into the pixel stream, 2-cycle pipeline
// Optional high-score register and second row: SCORE_HISCORE_EN
module score_render
  import score_render_pkg::*;
#(
  parameter int ORIGIN_X   = 560,
  parameter int ORIGIN_Y   = 16,
  parameter int SCALE_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score,
  input  logic        game_tick,
  input  logic        game_over,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
`ifdef SCORE_HISCORE_EN
  output logic [15:0] hiscore,
`endif
  output logic        pixel_on
);

`ifdef SCORE_HISCORE_EN
  localparam int NUM_ROWS = 2;
`else
  localparam int NUM_ROWS = 1;
`endif

  localparam int X_END = ORIGIN_X + ((NUM_DIGITS * CELL_W) << SCALE_LOG2);

  logic [15:0] shown;
  logic [15:0] row_val [NUM_ROWS];
  logic [NUM_ROWS-1:0] lit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         shown <= '0;
    else if (game_tick) shown <= score;
  end

  assign row_val[0] = shown;

`ifdef SCORE_HISCORE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           hiscore <= '0;
    else if (game_over && score > hiscore) hiscore <= score;
  end

  assign row_val[1] = hiscore;
`else
  logic unused_game_over;
  assign unused_game_over = game_over;
`endif

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    localparam int OY    = ORIGIN_Y + r * (HI_ROW_GAP << SCALE_LOG2);
    localparam int Y_END = OY + (GLYPH_H << SCALE_LOG2);

    logic [9:0]  dx, dy;
    logic [3:0]  ux;
    logic [2:0]  uy;
    logic        in_c, blank_c;
    logic [3:0]  digit_c;
    logic        s1_in, s1_blank;
    logic [3:0]  s1_digit;
    logic [1:0]  s1_col;
    logic [2:0]  s1_row;
    logic [2:0]  pattern;
    logic        col_bit;

    // Bounds are compared in 32-bit so a region running past 1023 clips instead of wrapping.
    assign in_c = (int'(hpos) >= ORIGIN_X) && (int'(hpos) < X_END) &&
                  (int'(vpos) >= OY)       && (int'(vpos) < Y_END);
    assign dx = hpos - 10'(ORIGIN_X);
    assign dy = vpos - 10'(OY);
    assign ux = 4'(dx >> SCALE_LOG2);
    assign uy = 3'(dy >> SCALE_LOG2);

    always_comb begin
      digit_c = row_val[r][3:0];
      blank_c = 1'b0;
      case (ux[3:2])
        2'd0: begin digit_c = row_val[r][15:12]; blank_c = (row_val[r][15:12] == 4'd0); end
        2'd1: begin digit_c = row_val[r][11:8];  blank_c = (row_val[r][15:8]  == 8'd0); end
        2'd2: begin digit_c = row_val[r][7:4];   blank_c = (row_val[r][15:4]  == 12'd0); end
        default: begin digit_c = row_val[r][3:0]; blank_c = 1'b0; end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_in    <= 1'b0;
        s1_blank <= 1'b0;
        s1_digit <= '0;
        s1_col   <= '0;
        s1_row   <= '0;
      end else begin
        s1_in    <= in_c;
        s1_blank <= blank_c;
        s1_digit <= digit_c;
        s1_col   <= ux[1:0];
        s1_row   <= uy;
      end
    end

    score_glyph_rom u_rom (
      .digit   (s1_digit),
      .row     (s1_row),
      .pattern (pattern)
    );

    always_comb begin
      col_bit = 1'b0;
      case (s1_col)
        2'd0:    col_bit = pattern[2];
        2'd1:    col_bit = pattern[1];
        2'd2:    col_bit = pattern[0];
        default: col_bit = 1'b0;
      endcase
    end

    assign lit[r] = s1_in & ~s1_blank & col_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel_on <= 1'b0;
    else        pixel_on <= |lit;
  end

endmodule

// File: tb/tb_score_render.sv
// tb/tb_score_render.sv - randomized bench for score_render against a screen-level pixel model
// Hiscore checks build only with SCORE_HISCORE_EN
module tb_score_render;

  localparam int OX = 560;
  localparam int OY = 16;
  localparam int S  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] score = '0;
  logic        game_tick = 1'b0;
  logic        game_over = 1'b0;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic        pixel_on;
`ifdef SCORE_HISCORE_EN
  logic [15:0] hiscore;
`endif

  int checks = 0;
  int passed = 0;

  score_render #(.ORIGIN_X(OX), .ORIGIN_Y(OY), .SCALE_LOG2(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .score     (score),
    .game_tick (game_tick),
    .game_over (game_over),
    .hpos      (hpos),
    .vpos      (vpos),
`ifdef SCORE_HISCORE_EN
    .hiscore   (hiscore),
`endif
    .pixel_on  (pixel_on)
  );

  always #5 clk = ~clk;

  int font [10][5] = '{
    '{7, 5, 5, 5, 7}, '{2, 6, 2, 2, 7}, '{7, 1, 7, 4, 7}, '{7, 1, 7, 1, 7}, '{5, 5, 7, 1, 1},
    '{7, 4, 7, 1, 7}, '{7, 4, 7, 5, 7}, '{7, 1, 1, 1, 1}, '{7, 5, 7, 5, 7}, '{7, 5, 7, 1, 7}
  };

  function automatic int row_px(int h, int v, int val, int oy);
    int ux, uy, d, c, nib;
    if (h < OX || h >= OX + (16 << S) || v < oy || v >= oy + (5 << S)) return 0;
    ux = (h - OX) >> S;
    uy = (v - oy) >> S;
    d = ux / 4;
    c = ux % 4;
    if (c == 3) return 0;
    if (d < 3 && (val >> (4 * (3 - d))) == 0) return 0;
    nib = (val >> (4 * (3 - d))) & 15;
    if (nib > 9) return 1;
    return (font[nib][uy] >> (2 - c)) & 1;
  endfunction

  int shown_m, hi_m, exp1, exp2;

  function automatic int screen_px(int h, int v, int sh, int hi);
    int p;
    p = row_px(h, v, sh, OY);
`ifdef SCORE_HISCORE_EN
    p = p | row_px(h, v, hi, OY + (7 << S));
`endif
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_m <= 0; hi_m <= 0; exp1 <= 0; exp2 <= 0;
    end else begin
      exp2 <= exp1;
      exp1 <= screen_px(int'(hpos), int'(vpos), shown_m, hi_m);
      if (game_tick) shown_m <= int'(score);
      if (game_over && int'(score) > hi_m) hi_m <= int'(score);
    end
  end

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    check("pixel_model", int'(pixel_on), exp2);
`ifdef SCORE_HISCORE_EN
    check("hiscore_model", int'(hiscore), hi_m);
`endif
  end

  task automatic px(int h, int v, int req, string name);
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v);
    @(negedge clk);
    @(negedge clk);
    check(name, int'(pixel_on), req);
  endtask

  task automatic tick(logic [15:0] val);
    @(negedge clk);
    score = val; game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
  endtask

  task automatic scan(int x0, int x1, int y0, int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        @(negedge clk);
        hpos = 10'(x); vpos = 10'(y);
      end
  endtask

  initial begin
    hpos = 10'd560; vpos = 10'd16;
    repeat (3) @(negedge clk);
    check("reset_pixel", int'(pixel_on), 0);
`ifdef SCORE_HISCORE_EN
    check("reset_hiscore", int'(hiscore), 0);
`endif
    rst_n = 1'b1;

    check("model_8000_origin", row_px(560, 16, 'h8000, OY), 1);
    check("model_8000_col1row1", row_px(563, 18, 'h8000, OY), 0);
    check("model_8000_gap", row_px(566, 16, 'h8000, OY), 0);
    check("model_0042_blank", row_px(560, 16, 'h0042, OY), 0);

    px(584, 16, 1, "zero_shows_ones");
    tick(16'h0042);
    scan(556, 600, 14, 28);
    px(560, 16, 0, "blank_thousands");
    px(570, 20, 0, "blank_hundreds");
    px(576, 16, 1, "tens4_r0c0");
    px(578, 16, 0, "tens4_r0c1");
    px(584, 24, 1, "ones2_r4c0");
    px(584, 18, 0, "ones2_r1c0");

    @(negedge clk); score = 16'h0999;
    px(568, 16, 0, "no_tick_unchanged");
    tick(16'h0999);
    px(568, 16, 1, "tick_999_hundreds");
    px(560, 16, 0, "tick_999_thousands_blank");
    scan(556, 600, 14, 28);

    tick(16'h8000);
    px(560, 16, 1, "lat_origin");
    px(559, 16, 0, "lat_left_edge");
    px(562, 18, 0, "g_col1_row1_a");
    px(563, 18, 0, "g_col1_row1_b");
    px(566, 16, 0, "gap_column");

    tick(16'h00A0);
    for (int y = 16; y <= 25; y += 3)
      for (int x = 576; x <= 581; x += 5) px(x, y, 1, "invalid_lit");
    px(586, 18, 0, "ones0_center");
    px(584, 18, 1, "ones0_left");

`ifdef SCORE_HISCORE_EN
    @(negedge clk); score = 16'h0123; game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
    check("hiscore_load", int'(hiscore), 'h0123);
    px(570, 30, 1, "hi_row_1");
    px(568, 30, 0, "hi_row_1_c0");
    px(584, 30, 1, "hi_row_3");
    px(560, 36, 0, "hi_row_blank");
    scan(556, 600, 28, 40);
    @(negedge clk); score = 16'h0099; game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
    check("hiscore_hold", int'(hiscore), 'h0123);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hpos = 10'($urandom_range(550, 600));
      vpos = 10'($urandom_range(10, 50));
      game_tick = ($urandom_range(0, 19) == 0);
      game_over = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) score = 16'($urandom);
      else if ($urandom_range(0, 9) == 0) score = 16'($urandom_range(0, 9) << (4 * $urandom_range(0, 3)));
    end
    @(negedge clk); game_tick = 1'b0; game_over = 1'b0;

    tick(16'h8000);
    px(560, 16, 1, "pre_reset_lit");
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset_clear", int'(pixel_on), 0);
    hpos = 10'd584; vpos = 10'd16;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_still0", int'(pixel_on), 0);
    @(negedge clk);
    check("post_reset_zero_lit", int'(pixel_on), 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
